// File: rtl/fifo_push_arb.sv
// fifo_push_arb: round-robin arbiter sharing one FIFO push port between
// NUM_REQ valid/ready producers. Grants are held for bursts of up to
// MAX_BURST beats and across any stalled beat, so the pushed data and id
// stay stable while the FIFO is full.
module fifo_push_arb #(
  parameter int REQ_IDX   = 2,
  parameter int SIZE      = 4,
  parameter int BURST_IDX = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2**REQ_IDX-1:0]     req_val,
  output logic [2**REQ_IDX-1:0]     req_rdy,
  input  logic [2**REQ_IDX*SIZE-1:0] req_data,
  output logic                      out_val,
  input  logic                      out_rdy,
  output logic [SIZE-1:0]           out_data,
  output logic [REQ_IDX-1:0]        out_id
);

  localparam int NUM_REQ   = 2**REQ_IDX;
  localparam int MAX_BURST = 2**BURST_IDX;
  // A one-beat burst needs no counter; keep one harmless bit so the
  // register always has a legal width.
  localparam int CNT_W     = (BURST_IDX > 0) ? BURST_IDX : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_reg;
  logic [REQ_IDX-1:0] ptr_reg;
  logic [REQ_IDX-1:0] owner_reg;
  logic [CNT_W-1:0]   beat_cnt_reg;

  logic [REQ_IDX-1:0] sel;
  logic [REQ_IDX-1:0] scan_idx;
  logic               found;
  logic               xfer;

  // Pick the requester: owner while locked, else first valid from ptr upward.
  always_comb begin
    sel      = ptr_reg;
    scan_idx = '0;
    found    = 1'b0;
    if (state_reg == LOCKED) begin
      sel = owner_reg;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        scan_idx = ptr_reg + REQ_IDX'(k);
        if (!found && req_val[scan_idx]) begin
          sel   = scan_idx;
          found = 1'b1;
        end
      end
    end
    // Outputs must read as idle/requester 0 while reset is held, even if
    // producers are already driving valid.
    if (!rst_n) begin
      sel = '0;
    end
  end

  // Zero-latency forwarding of the selected channel to the FIFO push side.
  always_comb begin
    req_rdy  = '0;
    out_val  = rst_n & req_val[sel];
    out_data = req_data[sel*SIZE +: SIZE];
    out_id   = sel;
    if (rst_n) begin
      req_rdy[sel] = out_rdy;
    end
  end

  assign xfer = out_val & out_rdy;

  // Grant state machine: lock on a push or stall, release on burst end or bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      owner_reg    <= '0;
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (xfer) begin
            if (MAX_BURST == 1) begin
              ptr_reg <= sel + 1'b1;
            end else begin
              state_reg    <= LOCKED;
              owner_reg    <= sel;
              beat_cnt_reg <= CNT_W'(1);
            end
          end else if (out_val) begin
            state_reg    <= LOCKED;
            owner_reg    <= sel;
            beat_cnt_reg <= '0;
          end
        end
        LOCKED: begin
          if (!req_val[owner_reg]) begin
            state_reg <= IDLE;
            ptr_reg   <= owner_reg + 1'b1;
          end else if (xfer) begin
            if (beat_cnt_reg == CNT_W'(MAX_BURST - 1)) begin
              state_reg <= IDLE;
              ptr_reg   <= owner_reg + 1'b1;
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/fifo_push_arb.md
Name: fifo_push_arb

Overview:
- Round-robin arbiter that shares the single push port of a FIFO queue between NUM_REQ producers.
- Each producer presents a valid/ready/data channel. The arbiter selects one producer and forwards its channel to the FIFO push side.
- It holds the grant for bursts of up to MAX_BURST beats, and for any stalled beat.
- It sits directly in front of the FIFO: out_val/out_rdy/out_data connect to the FIFO's in_val/in_rdy/in_data.

Parameters:
- REQ_IDX, 2, log2 of the number of requesters; NUM_REQ = 2**REQ_IDX (localparam).
- SIZE, 4, data width per requester; must match the FIFO slot width.
- BURST_IDX, 2, log2 of the burst limit; MAX_BURST = 2**BURST_IDX (localparam).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- req_val  in  NUM_REQ  per-requester valid.
- req_rdy  out  NUM_REQ  per-requester ready; at most one bit set.
- req_data  in  NUM_REQ*SIZE  requester i occupies bits [i*SIZE +: SIZE].
- out_val  out  1  push valid to FIFO.
- out_rdy  in  1  FIFO ready (FIFO not full).
- out_data  out  SIZE  push data to FIFO.
- out_id  out  REQ_IDX  index of the currently selected requester.

Behaviour:
- State registers:
  - state_reg: IDLE or LOCKED.
  - ptr_reg: REQ_IDX bits, highest-priority index.
  - owner_reg: REQ_IDX bits.
  - beat_cnt_reg: BURST_IDX bits; BURST_IDX=0 means a single beat and no counter.
- Reset values: state IDLE, ptr 0, owner 0, beat_cnt 0. Outputs during reset: out_val=0, req_rdy=0, out_id=0, out_data=req_data[0].
- Selection sel is combinational:
  - IDLE: first i with req_val[i]=1, scanning ptr_reg, ptr_reg+1, ... modulo NUM_REQ. If none is valid, sel=ptr_reg.
  - LOCKED: sel=owner_reg; other requesters are ignored.
- Forwarding is combinational, zero latency:
  - out_val = req_val[sel].
  - out_data = req_data[sel].
  - out_id = sel.
  - req_rdy[sel] = out_rdy; all other req_rdy bits = 0.
- A transfer is out_val & out_rdy in the same cycle. Exactly one requester beat is pushed per transfer. No data is dropped or duplicated.
- IDLE transitions:
  - Transfer and MAX_BURST=1: stay IDLE; ptr <= sel+1.
  - Transfer and MAX_BURST>1: go LOCKED; owner <= sel; beat_cnt <= 1.
  - out_val & !out_rdy (stall): go LOCKED; owner <= sel; beat_cnt <= 0. This keeps out_data/out_id stable while the FIFO is full.
  - No valid: hold all state.
- LOCKED transitions:
  - Transfer and beat_cnt == MAX_BURST-1: go IDLE; ptr <= owner+1.
  - Transfer otherwise: beat_cnt <= beat_cnt+1.
  - Stall: hold all state.
  - req_val[owner]=0: out_val=0 that cycle (one-cycle bubble); go IDLE; ptr <= owner+1.
- Requester rule: once req_val[i] is raised while i is selected and stalled, requester i holds req_val and data until req_rdy[i]. The arbiter does not check this.
- Wrap-around: ptr and owner arithmetic is modulo NUM_REQ (natural REQ_IDX-bit overflow); ptr 3 -> 0 when NUM_REQ=4.
- Fairness: any continuously valid requester is granted within (NUM_REQ-1)*(MAX_BURST+1) transfer-or-bubble cycles of out_rdy=1.
- Reset mid-burst: everything returns to reset values immediately. A partially pushed burst is simply truncated.

Test Plan:
- Params 2/4/2, out_rdy=1; req_val=4'b0110 held; r1 sends 0x1..0x8, r2 sends 0x9..0xF -> out_id=1 for 4 beats (0x1-0x4), then one bubble cycle is not expected; out_id=2 for 4 beats (0x9-0xC), then out_id=1 (0x5-0x8).
- req_val=4'b1000 pulsed one cycle with data 0x7 -> out_val=1, out_id=3, out_data=0x7, req_rdy=4'b1000. Next cycle: out_val=0 (bubble). Then IDLE with ptr=0.
- r0 valid with 0xA, out_rdy=0 for 3 cycles, r2 raises val in cycle 2 -> out_id=0, out_data=0xA, req_rdy=0 throughout. out_rdy=1 in cycle 4 -> 0xA transfers, req_rdy=4'b0001.
- After a burst by r2 (ptr=3), req_val=4'b1001 -> r3 is granted first (4 beats), then r0.
- Reset asserted after 2 of r1's 4 beats -> out_val=0, state IDLE, ptr=0. After release with req_val=4'b1010, r1 is granted.
- Connected to a 4-slot, SIZE=4 FIFO; r0 pushes 6 beats with no pops -> 4 accepted, then out_rdy=0 and req_rdy=0. After 1 pop, beat 5 is accepted. FIFO pop order is beats 1..5 exactly.
